signed_mult_accumulate: RTL and testbench

- Sequential radix-2 Booth signed multiplier with a final accumulate step: Product = Multiplier × Multiplicand + Addend.
- It is the inverse of the signed divider. It rebuilds a dividend from quotient, divisor and remainder.
- Used as the divider's check datapath and as a general multiply unit.
- Start/Busy/Done handshake; one operation in flight.

---
 rtl/signed_mult_accumulate.sv | 117 +++++++++++
 tb/tb_signed_mult_accumulate.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/signed_mult_accumulate.sv
// Sequential radix-2 Booth signed multiplier with a final accumulate:
// product_o = multiplier_i * multiplicand_i + addend_i, Start/Busy/Done handshake.
module signed_mult_accumulate #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   addend_i,
    output logic [2*WIDTH-1:0] product_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     addend_q, addend_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       mcand_ext;
    logic [WIDTH:0]       sum;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            addend_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            addend_q  <= addend_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        addend_d  = addend_q;
        product_d = product_q;

        // A carries one guard bit so subtracting the most-negative multiplicand fits
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        case ({q_q[0], qm1_q})
            2'b01:   sum = a_q + mcand_ext;
            2'b10:   sum = a_q - mcand_ext;
            default: sum = a_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d  = multiplicand_i;
                    addend_d = addend_i;
                    q_d      = multiplier_i;
                    a_d      = '0;
                    qm1_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = {sum[WIDTH], sum[WIDTH:1]};
                q_d   = {sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                product_d = {a_q[WIDTH-1:0], q_q}
                          + {{WIDTH{addend_q[WIDTH-1]}}, addend_q};
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign product_o = product_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_signed_mult_accumulate.sv
// Self-checking bench: cycle-level behavioural model plus directed literal cases
// and randomized back-to-back traffic for signed_mult_accumulate (WIDTH=4).
module tb_signed_mult_accumulate;

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  mult;
    logic [W-1:0]  mcand;
    logic [W-1:0]  addend;
    logic [PW-1:0] product;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    // Model: cycles of busy remaining after an accepted start, expected result
    int            m_cnt = 0;
    logic [PW-1:0] m_res = '0;
    logic [PW-1:0] m_prod = '0;

    signed_mult_accumulate #(.WIDTH(W)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .start_i        (start),
        .multiplier_i   (mult),
        .multiplicand_i (mcand),
        .addend_i       (addend),
        .product_o      (product),
        .busy_o         (busy),
        .done_o         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] mac(input logic [W-1:0] m, input logic [W-1:0] c,
                                          input logic [W-1:0] a);
        int mi, ci, ai;
        mi = int'($signed(m));
        ci = int'($signed(c));
        ai = int'($signed(a));
        return PW'(mi * ci + ai);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_prod <= '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt <= W + 2;
                m_res <= mac(mult, mcand, addend);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) m_prod <= m_res;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", 64'(busy), 64'(m_cnt != 0));
            check("model_done", 64'(done), 64'(m_cnt == 1));
            check("model_product", 64'(product), 64'(m_prod));
        end
    end

    // Drives one operation; optionally fires an ignored second start mid-run.
    task automatic do_op(input string name, input logic [W-1:0] m, input logic [W-1:0] c,
                         input logic [W-1:0] a, input logic [PW-1:0] exp, input bit ignored);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        logic [PW-1:0] got = '0;
        mult   = m;
        mcand  = c;
        addend = a;
        start  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (ignored && i == 2) begin
                mult   = 4'd1;
                mcand  = 4'd1;
                addend = 4'd1;
                start  = 1'b1;
            end
            if (ignored && i == 3) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
                got = product;
            end
            if (!busy && i > 1) break;
        end
        check({name, "_product"}, 64'(got), 64'(exp));
        check({name, "_done_latency"}, 64'(done_at), 64'(W + 2));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 2));
        check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int done_seen;
        rst    = 1'b1;
        start  = 1'b0;
        mult   = '0;
        mcand  = '0;
        addend = '0;
        @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_product", 64'(product), 64'h00);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        do_op("neg3x5p1", 4'b1101, 4'd5, 4'd1, 8'hF2, 0);
        do_op("7xm8", 4'd7, 4'b1000, 4'd0, 8'hC8, 0);
        do_op("m8xm8p7", 4'b1000, 4'b1000, 4'd7, 8'h47, 0);
        do_op("0xm2pm2", 4'd0, 4'b1110, 4'b1110, 8'hFE, 0);
        do_op("3x4_ignored", 4'd3, 4'd4, 4'd0, 8'h0C, 1);

        // Abort with reset sampled at the second RUN step
        mult   = 4'd5;
        mcand  = 4'd5;
        addend = 4'd0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_product", 64'(product), 64'h00);
        check("abort_busy", 64'(busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        do_op("2x3p1", 4'd2, 4'd3, 4'd1, 8'h07, 0);

        // Random traffic, start often held high for back-to-back operations
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) != 0);
            mult   = W'($urandom);
            mcand  = W'($urandom);
            addend = W'($urandom);
            rst    = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("final_idle", 64'(busy), 64'd0);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
